// File: rtl/moore_pkg.sv
// Shared definitions for the 4-state Moore encoder and its stream decoder.
// State encodings here are the wire format; the encoder must use the same values.
package moore_pkg;

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_t;

  typedef enum logic {
    SYNC   = 1'b0,
    RESYNC = 1'b1
  } dec_fsm_t;

  localparam int ERR_COUNT_W = 8;

  // Returns {legal, bit}: the encoder input x that moves prev to next.
  function automatic logic [1:0] decode_bit(input state_t prev, input state_t next);
    logic [1:0] result;
    result = 2'b00;
    case (prev)
      S0: begin
        if (next == S3)      result = 2'b11;
        else if (next == S2) result = 2'b10;
      end
      S1: begin
        if (next == S1)      result = 2'b11;
        else if (next == S3) result = 2'b10;
      end
      S2: begin
        if (next == S2)      result = 2'b11;
        else if (next == S3) result = 2'b10;
      end
      S3: begin
        if (next == S0)      result = 2'b11;
        else if (next == S2) result = 2'b10;
      end
      default: result = 2'b00;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/moore_word_packer.sv
// Packs recovered bits LSB-first into WIDTH-bit words and holds each word
// behind a valid/ready handshake; words completed while one is pending are dropped.
module moore_word_packer #(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             bit_clear,
  input  logic             data_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic [CW-1:0]    bit_count,
  output logic             overflow
);

  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] word_next;
  logic [CW-1:0]    bit_count_reg;
  logic [WIDTH-1:0] data_out_reg;
  logic             data_valid_reg;
  logic             overflow_reg;
  logic             last_bit;
  logic             handshake;
  logic             word_done;

  // Each slot captures the incoming bit when the count points at it, so the
  // first bit of a word always lands in bit 0.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_slot
      assign word_next[gi] = (bit_count_reg == CW'(gi)) ? bit_in : shift_reg[gi];
    end
  endgenerate

  assign last_bit  = (bit_count_reg == CW'(WIDTH - 1));
  assign handshake = data_valid_reg && data_ready;
  assign word_done = bit_valid && !bit_clear && last_bit;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shift_reg      <= '0;
      bit_count_reg  <= '0;
      data_out_reg   <= '0;
      data_valid_reg <= 1'b0;
      overflow_reg   <= 1'b0;
    end else begin
      if (bit_clear) begin
        bit_count_reg <= '0;
      end else if (bit_valid) begin
        shift_reg     <= word_next;
        bit_count_reg <= last_bit ? '0 : bit_count_reg + CW'(1);
      end

      // A word being accepted this cycle frees the output slot for the new one.
      if (word_done && (!data_valid_reg || handshake)) begin
        data_out_reg   <= word_next;
        data_valid_reg <= 1'b1;
      end else begin
        if (handshake) data_valid_reg <= 1'b0;
        if (word_done) overflow_reg   <= 1'b1;
      end
    end
  end

  assign data_out   = data_out_reg;
  assign data_valid = data_valid_reg;
  assign bit_count  = bit_count_reg;
  assign overflow   = overflow_reg;

endmodule

// File: rtl/moore_stream_decoder.sv
// Rebuilds the encoder's serial input from its observed state stream and flags
// illegal transitions. Define MOORE_DEC_ERRCNT_EN to add the saturating err_count output.
module moore_stream_decoder
  import moore_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       y_in,
  input  logic             y_valid,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic [CW-1:0]    bit_count,
  output logic             err,
  output logic             overflow
`ifdef MOORE_DEC_ERRCNT_EN
  ,
  output logic [ERR_COUNT_W-1:0] err_count
`endif
);

  dec_fsm_t   fsm_reg, fsm_next;
  state_t     tracked_reg, tracked_next;
  logic       err_reg, err_next;
  logic [1:0] dec_result;
  logic       bit_valid;
  logic       bit_clear;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fsm_reg     <= SYNC;
      tracked_reg <= S0;
      err_reg     <= 1'b0;
    end else begin
      fsm_reg     <= fsm_next;
      tracked_reg <= tracked_next;
      err_reg     <= err_next;
    end
  end

  // Tracked state always follows the stream, so an illegal jump re-anchors
  // decoding on the state actually observed.
  always_comb begin
    dec_result   = decode_bit(tracked_reg, state_t'(y_in));
    fsm_next     = fsm_reg;
    tracked_next = tracked_reg;
    err_next     = 1'b0;
    bit_valid    = 1'b0;
    bit_clear    = 1'b0;
    if (y_valid) begin
      tracked_next = state_t'(y_in);
      if (dec_result[1]) begin
        bit_valid = 1'b1;
        fsm_next  = SYNC;
      end else begin
        err_next  = 1'b1;
        bit_clear = (fsm_reg == SYNC);
        fsm_next  = RESYNC;
      end
    end
  end

  moore_word_packer #(.WIDTH(WIDTH)) u_packer (
    .clock      (clock),
    .reset      (reset),
    .bit_valid  (bit_valid),
    .bit_in     (dec_result[0]),
    .bit_clear  (bit_clear),
    .data_ready (data_ready),
    .data_out   (data_out),
    .data_valid (data_valid),
    .bit_count  (bit_count),
    .overflow   (overflow)
  );

  assign err = err_reg;

`ifdef MOORE_DEC_ERRCNT_EN
  logic [ERR_COUNT_W-1:0] err_count_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_count_reg <= '0;
    end else if (err_next && (err_count_reg != {ERR_COUNT_W{1'b1}})) begin
      err_count_reg <= err_count_reg + ERR_COUNT_W'(1);
    end
  end

  assign err_count = err_count_reg;
`endif

endmodule

// File: tb/tb_moore_stream_decoder.sv
// Bench for moore_stream_decoder: WIDTH=4 and WIDTH=8 instances share one stream.
// Honours MOORE_DEC_ERRCNT_EN when the design is built with it.
module tb_moore_stream_decoder;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] y_in = 2'd0;
  logic       y_valid = 1'b0;
  logic       data_ready = 1'b0;

  logic [7:0] do8;
  logic       dv8, err8, ovf8;
  logic [3:0] bc8;
  logic [3:0] do4;
  logic       dv4, err4, ovf4;
  logic [2:0] bc4;
`ifdef MOORE_DEC_ERRCNT_EN
  logic [7:0] ec8, ec4;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0] enc_state = 2'd0;

  always #5 clock = ~clock;

  moore_stream_decoder #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .y_in(y_in), .y_valid(y_valid),
    .data_out(do8), .data_valid(dv8), .data_ready(data_ready),
    .bit_count(bc8), .err(err8), .overflow(ovf8)
`ifdef MOORE_DEC_ERRCNT_EN
    , .err_count(ec8)
`endif
  );

  moore_stream_decoder #(.WIDTH(4)) dut4 (
    .clock(clock), .reset(reset), .y_in(y_in), .y_valid(y_valid),
    .data_out(do4), .data_valid(dv4), .data_ready(data_ready),
    .bit_count(bc4), .err(err4), .overflow(ovf4)
`ifdef MOORE_DEC_ERRCNT_EN
    , .err_count(ec4)
`endif
  );

  // Encoder next-state rule; the model decodes by asking which x reaches y.
  function automatic logic [1:0] enc(input logic [1:0] s, input logic x);
    case (s)
      2'd0:    return x ? 2'd3 : 2'd2;
      2'd1:    return x ? 2'd1 : 2'd3;
      2'd2:    return x ? 2'd2 : 2'd3;
      default: return x ? 2'd0 : 2'd2;
    endcase
  endfunction

  typedef struct packed {
    logic [1:0]  prev;
    logic [5:0]  cnt;
    logic [31:0] word_acc;
    logic        dv;
    logic [31:0] dout;
    logic        ovf;
    logic        err;
    logic [8:0]  errcnt;
  } model_t;

  model_t m4 = '0;
  model_t m8 = '0;

  function automatic model_t model_step(input model_t m, input int w, input logic yv,
                                        input logic [1:0] y, input logic rdy);
    model_t n;
    logic took, hit0, hit1;
    logic [31:0] word;
    n = m;
    n.err = 1'b0;
    took = m.dv && rdy;
    if (took) n.dv = 1'b0;
    if (yv) begin
      hit0 = (enc(m.prev, 1'b0) == y);
      hit1 = (enc(m.prev, 1'b1) == y);
      n.prev = y;
      if (!(hit0 || hit1)) begin
        n.err = 1'b1;
        n.cnt = '0;
        n.word_acc = '0;
        if (m.errcnt < 9'd255) n.errcnt = m.errcnt + 9'd1;
      end else begin
        n.word_acc = m.word_acc | (32'(hit1) << m.cnt);
        n.cnt = m.cnt + 6'd1;
        if (int'(n.cnt) == w) begin
          word = n.word_acc;
          n.cnt = '0;
          n.word_acc = '0;
          if (!m.dv || took) begin
            n.dv = 1'b1;
            n.dout = word;
          end else begin
            n.ovf = 1'b1;
          end
        end
      end
    end
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("dv8", 32'(dv8), 32'(m8.dv));
    chk("do8", 32'(do8), 32'(m8.dout[7:0]));
    chk("bc8", 32'(bc8), 32'(m8.cnt));
    chk("err8", 32'(err8), 32'(m8.err));
    chk("ovf8", 32'(ovf8), 32'(m8.ovf));
    chk("dv4", 32'(dv4), 32'(m4.dv));
    chk("do4", 32'(do4), 32'(m4.dout[3:0]));
    chk("bc4", 32'(bc4), 32'(m4.cnt));
    chk("err4", 32'(err4), 32'(m4.err));
    chk("ovf4", 32'(ovf4), 32'(m4.ovf));
`ifdef MOORE_DEC_ERRCNT_EN
    chk("ec8", 32'(ec8), 32'(m8.errcnt));
    chk("ec4", 32'(ec4), 32'(m4.errcnt));
`endif
  endtask

  task automatic step_cycle(input logic yv, input logic [1:0] y, input logic rdy);
    @(negedge clock);
    y_valid = yv;
    y_in = y;
    data_ready = rdy;
    @(posedge clock);
    m4 = model_step(m4, 4, yv, y, rdy);
    m8 = model_step(m8, 8, yv, y, rdy);
    #1;
    $display("cycle yv=%0b y=%0d rdy=%0b | w8 dv=%0b do=%02h bc=%0d err=%0b ovf=%0b | w4 dv=%0b do=%0h bc=%0d",
             yv, y, rdy, dv8, do8, bc8, err8, ovf8, dv4, do4, bc4);
    check_all();
  endtask

  task automatic send_bits(input logic [31:0] bits, input int n, input logic rdy);
    logic [1:0] y;
    for (int i = 0; i < n; i++) begin
      y = enc(enc_state, bits[i]);
      enc_state = y;
      step_cycle(1'b1, y, rdy);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    y_valid = 1'b0;
    y_in = 2'd0;
    data_ready = 1'b0;
    #1;
    m4 = '0;
    m8 = '0;
    enc_state = 2'd0;
    check_all();
    @(negedge clock);
    reset = 1'b1;
  endtask

  typedef struct packed {
    logic       yv;
    logic [1:0] y;
    logic       rdy;
    logic [3:0] bc8;
    logic       dv8;
    logic [7:0] do8;
    logic       err;
    logic [2:0] bc4;
    logic       dv4;
    logic [3:0] do4;
  } vec_t;

  vec_t tbl [9];

  initial begin
    logic [1:0] ry;
    logic       rx, ryv;

    // x = 1,0,0,1,1,0,1,0 from S0: 8-bit word 0x59, 4-bit words 9 then 5.
    tbl[0] = '{1'b1, 2'd3, 1'b1, 4'd1, 1'b0, 8'h00, 1'b0, 3'd1, 1'b0, 4'h0};
    tbl[1] = '{1'b1, 2'd2, 1'b1, 4'd2, 1'b0, 8'h00, 1'b0, 3'd2, 1'b0, 4'h0};
    tbl[2] = '{1'b1, 2'd3, 1'b1, 4'd3, 1'b0, 8'h00, 1'b0, 3'd3, 1'b0, 4'h0};
    tbl[3] = '{1'b1, 2'd0, 1'b1, 4'd4, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 4'h9};
    tbl[4] = '{1'b1, 2'd3, 1'b1, 4'd5, 1'b0, 8'h00, 1'b0, 3'd1, 1'b0, 4'h9};
    tbl[5] = '{1'b1, 2'd2, 1'b1, 4'd6, 1'b0, 8'h00, 1'b0, 3'd2, 1'b0, 4'h9};
    tbl[6] = '{1'b1, 2'd2, 1'b1, 4'd7, 1'b0, 8'h00, 1'b0, 3'd3, 1'b0, 4'h9};
    tbl[7] = '{1'b1, 2'd3, 1'b1, 4'd0, 1'b1, 8'h59, 1'b0, 3'd0, 1'b1, 4'h5};
    tbl[8] = '{1'b0, 2'd0, 1'b1, 4'd0, 1'b0, 8'h59, 1'b0, 3'd0, 1'b0, 4'h5};

    #1;
    check_all();
    repeat (2) @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 9; i++) begin
      step_cycle(tbl[i].yv, tbl[i].y, tbl[i].rdy);
      chk($sformatf("tbl%0d_bc8", i), 32'(bc8), 32'(tbl[i].bc8));
      chk($sformatf("tbl%0d_dv8", i), 32'(dv8), 32'(tbl[i].dv8));
      chk($sformatf("tbl%0d_do8", i), 32'(do8), 32'(tbl[i].do8));
      chk($sformatf("tbl%0d_err", i), 32'(err8), 32'(tbl[i].err));
      chk($sformatf("tbl%0d_bc4", i), 32'(bc4), 32'(tbl[i].bc4));
      chk($sformatf("tbl%0d_dv4", i), 32'(dv4), 32'(tbl[i].dv4));
      chk($sformatf("tbl%0d_do4", i), 32'(do4), 32'(tbl[i].do4));
    end

    // Illegal S0->S1 after three bits, then a legal S1->S1 restarts the word.
    do_reset();
    send_bits(32'b100, 3, 1'b1);
    chk("pre_err_bc8", 32'(bc8), 32'd3);
    step_cycle(1'b1, 2'd1, 1'b1);
    chk("err_pulse", 32'(err8), 32'd1);
    chk("err_bc8", 32'(bc8), 32'd0);
    step_cycle(1'b1, 2'd1, 1'b1);
    chk("resync_err", 32'(err8), 32'd0);
    chk("resync_bc8", 32'(bc8), 32'd1);
    enc_state = 2'd1;
    step_cycle(1'b0, 2'd0, 1'b1);
    chk("idle_err", 32'(err8), 32'd0);

    // Two words complete with no consumer: first is held, second is dropped.
    do_reset();
    send_bits(32'hA5, 8, 1'b0);
    send_bits(32'h3C, 8, 1'b0);
    chk("ovf_do8", 32'(do8), 32'h0000_00A5);
    chk("ovf_dv8", 32'(dv8), 32'd1);
    chk("ovf_flag8", 32'(ovf8), 32'd1);
    chk("ovf_do4", 32'(do4), 32'h5);
    chk("ovf_flag4", 32'(ovf4), 32'd1);
    step_cycle(1'b0, 2'd0, 1'b1);
    chk("ovf_drain_dv8", 32'(dv8), 32'd0);
    chk("ovf_sticky8", 32'(ovf8), 32'd1);

    // Reset asserted between edges with a pending word and a partial word.
    do_reset();
    send_bits(32'h5A, 8, 1'b0);
    send_bits(32'h0F, 5, 1'b0);
    chk("mid_bc8", 32'(bc8), 32'd5);
    chk("mid_dv8", 32'(dv8), 32'd1);
    #3;
    reset = 1'b0;
    y_valid = 1'b0;
    #1;
    chk("async_dv8", 32'(dv8), 32'd0);
    chk("async_bc8", 32'(bc8), 32'd0);
    chk("async_do8", 32'(do8), 32'd0);
    chk("async_ovf8", 32'(ovf8), 32'd0);
    m4 = '0;
    m8 = '0;
    enc_state = 2'd0;
    @(negedge clock);
    reset = 1'b1;
    send_bits(32'b1001, 4, 1'b1);
    chk("post_rst_do4", 32'(do4), 32'h9);
    chk("post_rst_dv4", 32'(dv4), 32'd1);

    // Random stream, mostly legal, with random back-pressure.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      ryv = ($urandom_range(0, 3) != 0);
      rx = 1'($urandom_range(0, 1));
      ry = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : enc(enc_state, rx);
      if (ryv) enc_state = ry;
      step_cycle(ryv, ry, ($urandom_range(0, 2) != 0));
    end

`ifdef MOORE_DEC_ERRCNT_EN
    // S0->S0 repeated is illegal every time.
    do_reset();
    for (int i = 0; i < 300; i++) step_cycle(1'b1, 2'd0, 1'b1);
    chk("errcnt_sat8", 32'(ec8), 32'd255);
    chk("errcnt_sat4", 32'(ec4), 32'd255);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/moore_stream_decoder.md
Name: moore_stream_decoder

Overview:
- Receive-side counterpart of the 4-state Moore encoder (states S0..S3, output = state).
- Observes the encoder's 2-bit state stream, rebuilds the serial input bit x that caused each transition, and packs the bits into WIDTH-bit words.
- Reports illegal transitions and lost words.
- Sits downstream of the encoder, e.g. in the exam test bench or a link checker.

Parameters:
- WIDTH, 8, number of recovered bits per output word (2..32).

Ports:
- clock  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-low reset.
- y_in  input  2  encoder state sample.
- y_valid  input  1  y_in holds a new state this cycle.
- data_out  output  WIDTH  recovered word; first bit received is bit 0.
- data_valid  output  1  data_out holds an unconsumed word.
- data_ready  input  1  consumer accepts data_out when data_valid && data_ready.
- bit_count  output  $clog2(WIDTH+1)  bits collected in the current partial word.
- err  output  1  one-cycle pulse on an illegal transition.
- overflow  output  1  sticky; set when a completed word is dropped.

Behaviour:
- Reset (async, reset==0): every output goes to 0, tracked state = S0 (same as encoder reset), FSM = SYNC, shift register and bit_count cleared.
- Decode table (prev -> y_in = bit):
  - S0->S3=1, S0->S2=0
  - S1->S1=1, S1->S3=0
  - S2->S2=1, S2->S3=0
  - S3->S0=1, S3->S2=0
  - Any other pair is illegal.
- FSM states:
  - SYNC: each y_valid cycle, decode against tracked state. Legal: shift the bit in, tracked <= y_in, bit_count++. Illegal: err=1 for that cycle, drop the partial word (bit_count<=0), tracked <= y_in, go to RESYNC.
  - RESYNC: next y_valid is checked against tracked state. Legal: decode it as the first bit of a fresh word and go to SYNC. Illegal: err pulses again and tracked <= y_in.
- No y_valid: nothing changes; err stays 0.
- Word completion: the cycle the WIDTH-th bit is decoded, data_out <= shifted word, data_valid <= 1, bit_count <= 0. The word is visible 1 cycle after the last y_valid.
- Handshake:
  - data_valid holds, and data_out stays stable, until a cycle with data_valid && data_ready; it clears on the next edge.
  - Completion in the same cycle as a handshake: the new word loads and data_valid stays 1.
  - Completion while data_valid=1 and data_ready=0: the new word is dropped, overflow <= 1, data_out keeps the old word.
- overflow clears only on reset.
- Reset mid-word: the partial word and pending data_valid are discarded immediately.
- y_valid with an illegal pair on the WIDTH-th bit: no word is produced.

Optional Feature:
- MOORE_DEC_ERRCNT_EN defined:
  - Adds output err_count [7:0], a saturating count of illegal transitions.
  - Holds at 255; reset clears it to 0.
- Undefined: no err_count port and no counter logic; all other behaviour is identical.

Decomposition:
- Shared package moore_pkg:
  - state typedef/encodings S0=2'b00, S1=2'b01, S2=2'b10, S3=2'b11; the encoder must use these too.
  - Function decode_bit(prev, next) returning {legal, bit}.
- Sub-module moore_word_packer: shift register, bit_count, output register, valid/ready handshake and overflow. The top keeps the tracker/FSM and err.

Test Plan:
- Reset, then y_in 3,2,3,0 with WIDTH=4 and data_ready=1 -> bits 1,0,0,1 -> data_out=4'b1001, data_valid for 1 cycle, err never set.
- Encoder driven with x=1,0,0,1,1,0,1,0 (WIDTH=8) -> data_out=8'h59 one cycle after the 8th y_valid.
- Illegal pair S0->S1 after 3 valid bits -> err pulse, bit_count=0, FSM enters RESYNC. Next legal S1->S1 -> bit 1 starts a new word, bit_count=1.
- data_ready=0 while two full words complete -> first word held, second dropped, overflow=1.
- Assert reset mid-word with bit_count=5 and data_valid=1 -> all outputs 0 asynchronously. Next stream decodes from S0.
- With MOORE_DEC_ERRCNT_EN, drive 300 illegal pairs -> err_count saturates at 255.
